// File: rtl/addr_reg_pkg.sv
// rtl/addr_reg_pkg.sv - shared types, default widths and helpers for the address register bank
package addr_reg_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_WR_W   = 20;
  localparam int DEF_WR_LSB = 2;
  localparam int DEF_STEP   = 1;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } burst_state_t;

  // Width of a channel index; never zero so a single-channel bank still has a legal port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ar_channel.sv
// rtl/ar_channel.sv - one address register with load, step up/down and sticky wrap flag
module ar_channel #(
  parameter int DATA_W = 16,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              burst_step,
  input  logic              inc,
  input  logic              dec,
  output logic [DATA_W-1:0] ar,
  output logic              wrap
);

  localparam logic [DATA_W:0] STEP_EXT = (DATA_W+1)'(STEP);

  // The extra top bit of each result is the carry / borrow out of the register width.
  logic [DATA_W:0] up_sum;
  logic [DATA_W:0] dn_diff;

  assign up_sum  = {1'b0, ar} + STEP_EXT;
  assign dn_diff = {1'b0, ar} - STEP_EXT;

  // Register update: load beats burst step beats a lone inc or dec; inc+dec together holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar   <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      ar   <= load_data;
      wrap <= 1'b0;
    end else if (burst_step || (inc && !dec)) begin
      ar <= up_sum[DATA_W-1:0];
      if (up_sum[DATA_W]) wrap <= 1'b1;
    end else if (dec && !inc) begin
      ar <= dn_diff[DATA_W-1:0];
      if (dn_diff[DATA_W]) wrap <= 1'b1;
    end
  end

endmodule

// File: rtl/addr_reg_bank.sv
// rtl/addr_reg_bank.sv - bank of address registers with a burst address engine
module addr_reg_bank
  import addr_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WR_W   = DEF_WR_W,
  parameter int WR_LSB = DEF_WR_LSB,
  parameter int STEP   = DEF_STEP,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic [WR_W-1:0]              WRDec_out,
  input  logic [DATA_W-1:0]            A_BUS_out,
  input  logic [NUM_CH-1:0]            Inc_en,
  input  logic [NUM_CH-1:0]            Dec_en,
  input  logic                         Burst_start,
  input  logic [ch_idx_w(NUM_CH)-1:0]  Burst_ch,
  input  logic [LEN_W-1:0]             Burst_len,
  input  logic                         Burst_abort,
  input  logic                         Addr_ready,
  output logic [NUM_CH*DATA_W-1:0]     AR_out,
  output logic [NUM_CH-1:0]            Wrap_flag,
  output logic [DATA_W-1:0]            Addr_out,
  output logic                         Addr_valid,
  output logic                         Burst_busy,
  output logic                         Burst_done
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  burst_state_t       state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               running;
  logic               handshake;
  logic [DATA_W-1:0]  ar_q [NUM_CH];
  logic [NUM_CH-1:0]  active;

  // Decoder bits outside the channel window are deliberately ignored.
  logic unused_wr_bits;
  assign unused_wr_bits = ^WRDec_out;

  assign running   = (state_q == ST_RUN);
  assign handshake = running && Addr_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // The burst owns the latched channel's stepping while running; external inc/dec is masked.
    assign active[c] = running && (ch_q == CH_W'(c));

    ar_channel #(
      .DATA_W (DATA_W),
      .STEP   (STEP)
    ) u_ar (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .load       (WRDec_out[WR_LSB+c]),
      .load_data  (A_BUS_out),
      .burst_step (handshake && active[c]),
      .inc        (Inc_en[c] && !active[c]),
      .dec        (Dec_en[c] && !active[c]),
      .ar         (ar_q[c]),
      .wrap       (Wrap_flag[c])
    );

    assign AR_out[c*DATA_W +: DATA_W] = ar_q[c];
  end

  // Burst FSM state, latched channel and remaining beat count.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a zero-length request goes straight to DONE without issuing anything.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Burst_start) begin
          ch_d    = Burst_ch;
          cnt_d   = Burst_len;
          state_d = (Burst_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (handshake) cnt_d = cnt_q - LEN_W'(1);
        if (Burst_abort) begin
          state_d = ST_IDLE;
        end else if (handshake && (cnt_q == LEN_W'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst address mux; reads zero whenever no burst is running.
  always_comb begin
    Addr_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (active[c]) Addr_out = ar_q[c];
    end
  end

  assign Addr_valid = running;
  assign Burst_busy = (state_q != ST_IDLE);
  assign Burst_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_addr_reg_bank.sv
// tb/tb_addr_reg_bank.sv - self-checking bench for addr_reg_bank
module tb_addr_reg_bank;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [19:0] WRDec_out;
  logic [15:0] A_BUS_out;
  logic [1:0]  Inc_en;
  logic [1:0]  Dec_en;
  logic        Burst_start;
  logic [0:0]  Burst_ch;
  logic [7:0]  Burst_len;
  logic        Burst_abort;
  logic        Addr_ready;
  logic [31:0] AR_out;
  logic [1:0]  Wrap_flag;
  logic [15:0] Addr_out;
  logic        Addr_valid;
  logic        Burst_busy;
  logic        Burst_done;

  int checks   = 0;
  int failures = 0;

  int  m_ar   [2];
  bit  m_wrap [2];
  int  m_phase;
  int  m_ch;
  int  m_left;

  logic [15:0] acc_q [$];
  logic        rdy_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  addr_reg_bank dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .WRDec_out   (WRDec_out),
    .A_BUS_out   (A_BUS_out),
    .Inc_en      (Inc_en),
    .Dec_en      (Dec_en),
    .Burst_start (Burst_start),
    .Burst_ch    (Burst_ch),
    .Burst_len   (Burst_len),
    .Burst_abort (Burst_abort),
    .Addr_ready  (Addr_ready),
    .AR_out      (AR_out),
    .Wrap_flag   (Wrap_flag),
    .Addr_out    (Addr_out),
    .Addr_valid  (Addr_valid),
    .Burst_busy  (Burst_busy),
    .Burst_done  (Burst_done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_ar[0] = 0; m_ar[1] = 0;
    m_wrap[0] = 0; m_wrap[1] = 0;
    m_phase = 0; m_ch = 0; m_left = 0;
  endtask

  function automatic logic [31:0] exp_ar();
    return {16'(m_ar[1]), 16'(m_ar[0])};
  endfunction

  function automatic logic [15:0] exp_addr();
    return (m_phase == 1) ? 16'(m_ar[m_ch]) : 16'h0;
  endfunction

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_update();
    int n_ar [2];
    bit n_wrap [2];
    bit hs;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    hs = (m_phase == 1) && Addr_ready;
    for (int c = 0; c < 2; c++) begin
      n_ar[c]   = m_ar[c];
      n_wrap[c] = m_wrap[c];
      if (WRDec_out[2+c]) begin
        n_ar[c]   = int'(A_BUS_out);
        n_wrap[c] = 0;
      end else if (m_phase == 1 && c == m_ch) begin
        if (hs) n_ar[c] = m_ar[c] + 1;
      end else if (Inc_en[c] && !Dec_en[c]) begin
        n_ar[c] = m_ar[c] + 1;
      end else if (Dec_en[c] && !Inc_en[c]) begin
        n_ar[c] = m_ar[c] - 1;
      end
      if (n_ar[c] > 65535) begin n_ar[c] -= 65536; n_wrap[c] = 1; end
      if (n_ar[c] < 0)     begin n_ar[c] += 65536; n_wrap[c] = 1; end
    end
    m_ar = n_ar;
    m_wrap = n_wrap;
    case (m_phase)
      0: if (Burst_start) begin
           m_ch    = int'(Burst_ch);
           m_left  = int'(Burst_len);
           m_phase = (m_left > 0) ? 1 : 2;
         end
      1: begin
           if (hs) m_left--;
           if (Burst_abort) m_phase = 0;
           else if (m_left == 0) m_phase = 2;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_update();
    #1;
  endtask

  // Every falling edge: all outputs against the model, and log accepted burst addresses.
  always @(negedge Clock) begin
    chk("ar_out",     AR_out,     exp_ar());
    chk("wrap_flag",  Wrap_flag,  {m_wrap[1], m_wrap[0]});
    chk("addr_out",   Addr_out,   exp_addr());
    chk("addr_valid", Addr_valid, m_phase == 1);
    chk("burst_busy", Burst_busy, m_phase != 0);
    chk("burst_done", Burst_done, m_phase == 2);
    if (Addr_valid && Addr_ready) acc_q.push_back(Addr_out);
  end

  initial begin
    Reset_n = 1'b0; WRDec_out = '0; A_BUS_out = '0; Inc_en = '0; Dec_en = '0;
    Burst_start = 1'b0; Burst_ch = '0; Burst_len = '0; Burst_abort = 1'b0; Addr_ready = 1'b0;
    model_reset();
    repeat (2) cycle();
    Reset_n = 1'b1;
    chk("reset_ar", AR_out, 32'h0);
    chk("reset_valid", Addr_valid, 1'b0);

    // Loads through the decoder window
    WRDec_out = 20'h00004; A_BUS_out = 16'h5555; cycle(); WRDec_out = '0;
    chk("load_ch0", AR_out, 32'h0000_5555);
    WRDec_out = 20'hFFFFF; A_BUS_out = 16'h0000; cycle(); WRDec_out = '0;
    chk("load_all", AR_out, 32'h0);

    // Wrap flag set, hold on inc+dec, borrow, clear by load
    WRDec_out = 20'h00008; A_BUS_out = 16'hFFFF; cycle(); WRDec_out = '0;
    chk("load_ch1", AR_out, 32'hFFFF_0000);
    Inc_en = 2'b10; cycle(); Inc_en = '0;
    chk("inc_wrap_ar", AR_out, 32'h0);
    chk("inc_wrap_flag", Wrap_flag, 2'b10);
    Inc_en = 2'b11; Dec_en = 2'b11; cycle(); Inc_en = '0; Dec_en = '0;
    chk("incdec_hold", AR_out, 32'h0);
    Dec_en = 2'b01; cycle(); Dec_en = '0;
    chk("dec_borrow_ar", AR_out, 32'h0000_FFFF);
    chk("dec_borrow_flag", Wrap_flag, 2'b11);
    WRDec_out = 20'h00008; A_BUS_out = 16'h1234; cycle();
    chk("load_clears_flag", Wrap_flag, 2'b01);
    WRDec_out = 20'h00004; A_BUS_out = 16'h0100; cycle(); WRDec_out = '0;
    chk("load_ch0_0100", AR_out, 32'h1234_0100);
    chk("load_clears_flag0", Wrap_flag, 2'b00);

    // Four-beat burst with a stalled beat
    acc_q.delete();
    Burst_start = 1'b1; Burst_ch = 1'b0; Burst_len = 8'd4; cycle(); Burst_start = 1'b0;
    chk("burst_first_valid", Addr_valid, 1'b1);
    chk("burst_first_addr", Addr_out, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      Addr_ready = rdy_pat[i];
      cycle();
    end
    Addr_ready = 1'b0;
    chk("burst_done_pulse", Burst_done, 1'b1);
    chk("burst_end_ar", AR_out, 32'h1234_0104);
    cycle();
    chk("burst_done_once", Burst_done, 1'b0);
    chk("burst_beats", acc_q.size(), 4);
    for (int i = 0; i < acc_q.size() && i < 4; i++)
      chk("burst_beat_addr", acc_q[i], 64'(16'h0100 + 16'(i)));

    // Abort together with a handshake; start while running is ignored
    WRDec_out = 20'h00004; A_BUS_out = 16'h0200; cycle(); WRDec_out = '0;
    acc_q.delete();
    Burst_start = 1'b1; Burst_ch = 1'b0; Burst_len = 8'd5; cycle();
    Addr_ready = 1'b1; Burst_ch = 1'b1; Burst_len = 8'd2; cycle(); Burst_start = 1'b0;
    chk("restart_ignored_addr", Addr_out, 16'h0201);
    Burst_abort = 1'b1; cycle(); Burst_abort = 1'b0; Addr_ready = 1'b0;
    chk("abort_idle", Burst_busy, 1'b0);
    chk("abort_no_done", Burst_done, 1'b0);
    chk("abort_step_applied", AR_out, 32'h1234_0202);
    cycle();
    chk("abort_no_done_later", Burst_done, 1'b0);
    chk("abort_beats", acc_q.size(), 2);

    // Load into the active channel redirects the burst; inc/dec masked only on that channel
    acc_q.delete();
    Burst_start = 1'b1; Burst_ch = 1'b1; Burst_len = 8'd3; cycle(); Burst_start = 1'b0;
    Addr_ready = 1'b1; WRDec_out = 20'h00008; A_BUS_out = 16'h0500; Inc_en = 2'b11; cycle();
    WRDec_out = '0; Inc_en = '0;
    chk("run_load_wins", AR_out, 32'h0500_0203);
    Dec_en = 2'b10; cycle(); Dec_en = '0;
    cycle(); Addr_ready = 1'b0;
    chk("run_load_done", Burst_done, 1'b1);
    chk("run_load_ar", AR_out, 32'h0502_0203);
    cycle();
    chk("run_load_beats", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("run_load_beat0", acc_q[0], 16'h1234);
      chk("run_load_beat1", acc_q[1], 16'h0500);
      chk("run_load_beat2", acc_q[2], 16'h0501);
    end

    // Burst step carrying out of the top sets the wrap flag
    WRDec_out = 20'h00004; A_BUS_out = 16'hFFFF; cycle(); WRDec_out = '0;
    Burst_start = 1'b1; Burst_ch = 1'b0; Burst_len = 8'd1; cycle(); Burst_start = 1'b0;
    Addr_ready = 1'b1; cycle(); Addr_ready = 1'b0;
    chk("burst_wrap_done", Burst_done, 1'b1);
    chk("burst_wrap_ar", AR_out, 32'h0502_0000);
    chk("burst_wrap_flag", Wrap_flag, 2'b01);
    cycle();

    // Zero-length request
    Burst_start = 1'b1; Burst_len = 8'd0; cycle(); Burst_start = 1'b0;
    chk("zero_done", Burst_done, 1'b1);
    chk("zero_no_valid", Addr_valid, 1'b0);
    cycle();
    chk("zero_idle", Burst_busy, 1'b0);

    // Asynchronous reset in the middle of a burst
    Burst_start = 1'b1; Burst_ch = 1'b1; Burst_len = 8'd3; cycle(); Burst_start = 1'b0;
    Addr_ready = 1'b1;
    chk("pre_reset_valid", Addr_valid, 1'b1);
    #2 Reset_n = 1'b0; model_reset();
    #1;
    chk("async_reset_ar", AR_out, 32'h0);
    chk("async_reset_wrap", Wrap_flag, 2'b00);
    chk("async_reset_valid", Addr_valid, 1'b0);
    chk("async_reset_busy", Burst_busy, 1'b0);
    Addr_ready = 1'b0;
    cycle();
    Reset_n = 1'b1;
    cycle();
    chk("post_reset_idle", Burst_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
